// File: rtl/max31855_frame_decoder.sv
// rtl/max31855_frame_decoder.sv - MAX31855 frame decode, block average, fault debounce and BCD conversion
// A frame is taken on each chip-select rising edge; averaged readings feed a sequential double-dabble engine.
module max31855_frame_decoder #(
  parameter int FRAME_REVERSED = 1,
  parameter int AVG_LOG2       = 2,
  parameter int FAULT_CNT      = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        spi_cs_i,
  input  logic [31:0] frame_i,
  output logic [13:0] tc_avg_o,
  output logic [11:0] int_temp_o,
  output logic        fault_o,
  output logic [2:0]  fault_flags_o,
  output logic [15:0] bcd_o,
  output logic        sign_o,
  output logic        valid_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int               CNT_W    = AVG_LOG2 + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(1 << AVG_LOG2);
  localparam logic [3:0]       FCNT_MAX = 4'(FAULT_CNT);

  logic               cs_q, cs_d;
  logic               armed_q, armed_d;
  logic [31:0]        frame_q, frame_d;
  logic               frame_vld_q, frame_vld_d;
  logic signed [17:0] acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         fcnt_q, fcnt_d;
  logic               fault_q, fault_d;
  logic [2:0]         flags_q, flags_d;
  logic [11:0]        int_q, int_d;
  logic [13:0]        tc_avg_q, tc_avg_d;
  logic [1:0]         state_q, state_d;
  logic               pend_q, pend_d;
  logic [11:0]        mag_q, mag_d;
  logic [15:0]        work_q, work_d;
  logic [3:0]         sh_cnt_q, sh_cnt_d;
  logic               sign_work_q, sign_work_d;
  logic [15:0]        bcd_q, bcd_d;
  logic               sign_q, sign_d;
  logic               valid_q, valid_d;

  logic [31:0]        frame_in;
  logic               new_frame;
  logic signed [17:0] tc_ext, acc_sum, acc_shr;
  logic [CNT_W-1:0]   cnt_inc;
  logic               avg_rdy;
  logic [13:0]        tc_abs;
  logic [15:0]        work_adj;
  logic               unused_bits;

  // frame_q is always held in D-numbering: frame_q[31] is D31.
  always_comb begin
    frame_in = '0;
    for (int i = 0; i < 32; i++) begin
      frame_in[i] = (FRAME_REVERSED != 0) ? frame_i[31-i] : frame_i[i];
    end
  end

  // armed_q blocks a spurious event when chip-select is already high out of reset.
  assign new_frame = spi_cs_i & ~cs_q & armed_q;
  assign tc_ext    = {{4{frame_q[31]}}, frame_q[31:18]};
  assign acc_sum   = acc_q + tc_ext;
  assign acc_shr   = acc_sum >>> AVG_LOG2;
  assign cnt_inc   = cnt_q + CNT_W'(1);
  assign tc_abs    = tc_avg_q[13] ? (~tc_avg_q + 14'd1) : tc_avg_q;

  always_comb begin
    cs_d        = spi_cs_i;
    armed_d     = armed_q | ~spi_cs_i;
    frame_vld_d = new_frame;
    frame_d     = new_frame ? frame_in : frame_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    fcnt_d      = fcnt_q;
    fault_d     = fault_q;
    flags_d     = flags_q;
    int_d       = int_q;
    tc_avg_d    = tc_avg_q;
    avg_rdy     = 1'b0;
    if (frame_vld_q) begin
      flags_d = frame_q[2:0];
      if (frame_q[16]) begin
        if (fcnt_q != FCNT_MAX) fcnt_d = fcnt_q + 4'd1;
        if (fcnt_d == FCNT_MAX) fault_d = 1'b1;
      end else begin
        fcnt_d  = '0;
        fault_d = 1'b0;
        int_d   = frame_q[15:4];
        if (cnt_inc == CNT_FULL) begin
          tc_avg_d = acc_shr[13:0];
          acc_d    = '0;
          cnt_d    = '0;
          avg_rdy  = 1'b1;
        end else begin
          acc_d = acc_sum;
          cnt_d = cnt_inc;
        end
      end
    end
  end

  always_comb begin
    work_adj = '0;
    for (int i = 0; i < 4; i++) begin
      work_adj[4*i +: 4] = (work_q[4*i +: 4] >= 4'd5) ? work_q[4*i +: 4] + 4'd3 : work_q[4*i +: 4];
    end
  end

  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    mag_d       = mag_q;
    work_d      = work_q;
    sh_cnt_d    = sh_cnt_q;
    sign_work_d = sign_work_q;
    bcd_d       = bcd_q;
    sign_d      = sign_q;
    valid_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (avg_rdy || pend_q) begin
          state_d = S_LOAD;
          pend_d  = 1'b0;
        end
      end
      S_LOAD: begin
        mag_d       = tc_abs[13:2];
        sign_work_d = tc_avg_q[13];
        work_d      = '0;
        sh_cnt_d    = '0;
        state_d     = S_SHIFT;
      end
      S_SHIFT: begin
        work_d   = {work_adj[14:0], mag_q[11]};
        mag_d    = {mag_q[10:0], 1'b0};
        sh_cnt_d = sh_cnt_q + 4'd1;
        if (sh_cnt_q == 4'd11) state_d = S_DONE;
      end
      default: begin
        bcd_d   = work_q;
        sign_d  = sign_work_q;
        valid_d = 1'b1;
        state_d = S_IDLE;
      end
    endcase
    // Only the latest average matters, so one pending flag is enough.
    if (avg_rdy && (state_q != S_IDLE)) pend_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cs_q        <= 1'b0;
      armed_q     <= 1'b0;
      frame_q     <= '0;
      frame_vld_q <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      fcnt_q      <= '0;
      fault_q     <= 1'b0;
      flags_q     <= '0;
      int_q       <= '0;
      tc_avg_q    <= '0;
      state_q     <= S_IDLE;
      pend_q      <= 1'b0;
      mag_q       <= '0;
      work_q      <= '0;
      sh_cnt_q    <= '0;
      sign_work_q <= 1'b0;
      bcd_q       <= '0;
      sign_q      <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      cs_q        <= cs_d;
      armed_q     <= armed_d;
      frame_q     <= frame_d;
      frame_vld_q <= frame_vld_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      fcnt_q      <= fcnt_d;
      fault_q     <= fault_d;
      flags_q     <= flags_d;
      int_q       <= int_d;
      tc_avg_q    <= tc_avg_d;
      state_q     <= state_d;
      pend_q      <= pend_d;
      mag_q       <= mag_d;
      work_q      <= work_d;
      sh_cnt_q    <= sh_cnt_d;
      sign_work_q <= sign_work_d;
      bcd_q       <= bcd_d;
      sign_q      <= sign_d;
      valid_q     <= valid_d;
    end
  end

  assign unused_bits   = ^{frame_q[17], frame_q[3], tc_abs[1:0], acc_shr[17:14], work_adj[15]};

  assign tc_avg_o      = tc_avg_q;
  assign int_temp_o    = int_q;
  assign fault_o       = fault_q;
  assign fault_flags_o = flags_q;
  assign bcd_o         = bcd_q;
  assign sign_o        = sign_q;
  assign valid_o       = valid_q;

endmodule

// File: tb/tb_max31855_frame_decoder.sv
// tb/tb_max31855_frame_decoder.sv - self-checking bench for max31855_frame_decoder
// Two instances (1-frame and 4-frame averaging) share stimulus; a behavioural model predicts both.
module tb_max31855_frame_decoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        cs = 1'b0;
  logic [31:0] frame = '0;

  logic [13:0] tc_a, tc_b;
  logic [11:0] int_a, int_b;
  logic        flt_a, flt_b;
  logic [2:0]  fl_a, fl_b;
  logic [15:0] bcd_a, bcd_b;
  logic        sg_a, sg_b, vl_a, vl_b;

  max31855_frame_decoder #(.FRAME_REVERSED(1), .AVG_LOG2(0), .FAULT_CNT(3)) dut_a (
    .clk_i(clk), .rst_i(rst), .spi_cs_i(cs), .frame_i(frame),
    .tc_avg_o(tc_a), .int_temp_o(int_a), .fault_o(flt_a), .fault_flags_o(fl_a),
    .bcd_o(bcd_a), .sign_o(sg_a), .valid_o(vl_a));

  max31855_frame_decoder #(.FRAME_REVERSED(1), .AVG_LOG2(2), .FAULT_CNT(3)) dut_b (
    .clk_i(clk), .rst_i(rst), .spi_cs_i(cs), .frame_i(frame),
    .tc_avg_o(tc_b), .int_temp_o(int_b), .fault_o(flt_b), .fault_flags_o(fl_b),
    .bcd_o(bcd_b), .sign_o(sg_b), .valid_o(vl_b));

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int qa_bcd[$], qa_sign[$], qa_cyc[$];
  int qb_bcd[$], qb_sign[$];
  always @(negedge clk) begin
    if (vl_a) begin qa_bcd.push_back(int'(bcd_a)); qa_sign.push_back(int'(sg_a)); qa_cyc.push_back(cyc); end
    if (vl_b) begin qb_bcd.push_back(int'(bcd_b)); qb_sign.push_back(int'(sg_b)); end
  end

  // Behavioural model: index 0 = dut_a (1 frame), index 1 = dut_b (4 frames).
  int m_log2[2] = '{0, 2};
  int m_sum[2], m_n[2], m_avg[2], m_vld[2];
  int m_fcnt, m_fault, m_flags, m_int;

  function automatic int exp_bcd(input int avg);
    int w;
    w = ((avg < 0) ? -avg : avg) / 4;
    return ((w / 1000) % 10) * 4096 + ((w / 100) % 10) * 256 + ((w / 10) % 10) * 16 + (w % 10);
  endfunction

  function automatic int floor_div(input int a, input int b);
    int q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  function automatic logic [31:0] mk(input logic [13:0] tc, input logic flt, input logic [11:0] it, input logic [2:0] fl);
    return {tc, 1'b0, flt, it, 1'b0, fl};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin m_sum[k] = 0; m_n[k] = 0; m_avg[k] = 0; m_vld[k] = 0; end
    m_fcnt = 0; m_fault = 0; m_flags = 0; m_int = 0;
  endtask

  task automatic model_frame(input logic [31:0] m);
    int tc;
    tc = int'(m[31:18]);
    if (tc >= 8192) tc = tc - 16384;
    m_flags = int'(m[2:0]);
    m_vld[0] = 0; m_vld[1] = 0;
    if (m[16]) begin
      if (m_fcnt < 3) m_fcnt = m_fcnt + 1;
      if (m_fcnt == 3) m_fault = 1;
    end else begin
      m_fcnt = 0; m_fault = 0; m_int = int'(m[15:4]);
      for (int k = 0; k < 2; k++) begin
        m_sum[k] = m_sum[k] + tc;
        m_n[k] = m_n[k] + 1;
        if (m_n[k] == (1 << m_log2[k])) begin
          m_avg[k] = floor_div(m_sum[k], m_n[k]);
          m_vld[k] = 1; m_sum[k] = 0; m_n[k] = 0;
        end
      end
    end
  endtask

  task automatic clear_q();
    qa_bcd.delete(); qa_sign.delete(); qa_cyc.delete();
    qb_bcd.delete(); qb_sign.delete();
  endtask

  function automatic logic [31:0] rev(input logic [31:0] m);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = m[31-i];
    return r;
  endfunction

  task automatic do_reset();
    rst = 1'b1; cs = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
    clear_q();
  endtask

  // One frame: cs rises, frame_i scrambled while cs is steady, 34-clock spacing.
  task automatic send_frame(input logic [31:0] msb, output int e0);
    clear_q();
    frame = rev(msb);
    @(posedge clk); #1 cs = 1'b1;
    @(posedge clk); #1 e0 = cyc; frame = $urandom;
    repeat (16) @(posedge clk);
    #1 cs = 1'b0; frame = $urandom;
    repeat (17) @(posedge clk);
    #1;
    model_frame(msb);
  endtask

  task automatic test_reset();
    rst = 1'b1; cs = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if ({tc_a, int_a, flt_a, fl_a, bcd_a, sg_a, vl_a} !== '0) begin n_fail++; $display("FAIL reset_a got %h want 0", {tc_a, int_a, flt_a, fl_a, bcd_a, sg_a, vl_a}); end
    n_checks++; if ({tc_b, int_b, flt_b, fl_b, bcd_b, sg_b, vl_b} !== '0) begin n_fail++; $display("FAIL reset_b got %h want 0", {tc_b, int_b, flt_b, fl_b, bcd_b, sg_b, vl_b}); end
    do_reset();
  endtask

  task automatic test_single_good();
    int e0;
    send_frame(32'h01901900, e0);
    n_checks++; if (qa_bcd.size() != 1) begin n_fail++; $display("FAIL single_valid_count got %0d want 1", qa_bcd.size()); end
    else begin
      n_checks++; if (qa_cyc[0] - e0 != 15) begin n_fail++; $display("FAIL single_latency got %0d want 15 edges after capture", qa_cyc[0] - e0); end
      n_checks++; if (qa_bcd[0] != 32'h0025 || qa_sign[0] != 0) begin n_fail++; $display("FAIL single_bcd got %h/%0d want 0025/0", qa_bcd[0], qa_sign[0]); end
    end
    n_checks++; if (tc_a !== 14'h0064) begin n_fail++; $display("FAIL single_tc_avg got %h want 0064", tc_a); end
    n_checks++; if (int_a !== 12'h190) begin n_fail++; $display("FAIL single_int got %h want 190", int_a); end
    n_checks++; if (qb_bcd.size() != 0 || tc_b !== 14'h0) begin n_fail++; $display("FAIL single_b_noavg got %0d/%h want 0/0", qb_bcd.size(), tc_b); end
  endtask

  task automatic test_extremes();
    int e0;
    logic [13:0] tcs[3] = '{14'h3FD7, 14'h1FFF, 14'h2000};
    int want_bcd[3] = '{32'h0010, 32'h2047, 32'h2048};
    int want_sg[3] = '{1, 0, 1};
    for (int i = 0; i < 3; i++) begin
      send_frame(mk(tcs[i], 1'b0, 12'h0FF, 3'b000), e0);
      n_checks++; if (qa_bcd.size() != 1) begin n_fail++; $display("FAIL extreme%0d_count got %0d want 1", i, qa_bcd.size()); end
      else begin
        n_checks++; if (qa_bcd[0] != want_bcd[i] || qa_sign[0] != want_sg[i]) begin n_fail++; $display("FAIL extreme%0d_bcd got %h/%0d want %h/%0d", i, qa_bcd[0], qa_sign[0], want_bcd[i], want_sg[i]); end
      end
      n_checks++; if (tc_a !== tcs[i]) begin n_fail++; $display("FAIL extreme%0d_tc got %h want %h", i, tc_a, tcs[i]); end
    end
  endtask

  task automatic test_averaging();
    int e0;
    int vals[4] = '{100, 101, 102, 104};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      send_frame(mk(14'(vals[i]), 1'b0, 12'($urandom), 3'b000), e0);
      n_checks++; if (qb_bcd.size() != ((i == 3) ? 1 : 0)) begin n_fail++; $display("FAIL avg_count%0d got %0d want %0d", i, qb_bcd.size(), (i == 3) ? 1 : 0); end
    end
    n_checks++; if (tc_b !== 14'd101) begin n_fail++; $display("FAIL avg_tc got %0d want 101", tc_b); end
    n_checks++; if (qb_bcd.size() != 1 || qb_bcd[0] != 32'h0025 || qb_sign[0] != 0) begin n_fail++; $display("FAIL avg_bcd got %h want 0025", bcd_b); end
  endtask

  task automatic test_fault_debounce();
    int e0;
    logic [11:0] int_before;
    int_before = int_a;
    for (int i = 0; i < 3; i++) begin
      send_frame(32'h00010001, e0);
      n_checks++; if (flt_a !== (i == 2)) begin n_fail++; $display("FAIL fault_deb%0d got %b want %b", i, flt_a, (i == 2)); end
      n_checks++; if (fl_a !== 3'b001 || qa_bcd.size() != 0 || qb_bcd.size() != 0) begin n_fail++; $display("FAIL fault_flags%0d got %b/%0d want 001/0", i, fl_a, qa_bcd.size()); end
      n_checks++; if (int_a !== int_before) begin n_fail++; $display("FAIL fault_int%0d got %h want %h", i, int_a, int_before); end
    end
    send_frame(mk(14'd400, 1'b0, 12'h123, 3'b000), e0);
    n_checks++; if (flt_a !== 1'b0 || flt_b !== 1'b0 || fl_a !== 3'b000) begin n_fail++; $display("FAIL fault_clear got %b/%b want 0/000", flt_a, fl_a); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] f[3];
    f[0] = mk(14'd200, 1'b0, 12'h010, 3'b000);
    f[1] = mk(14'h3FC4, 1'b0, 12'h020, 3'b000);
    f[2] = mk(14'd4000, 1'b0, 12'h030, 3'b000);
    for (int run = 2; run <= 3; run++) begin
      do_reset();
      for (int i = 0; i < run; i++) begin
        frame = rev(f[i]);
        @(posedge clk); #1 cs = 1'b1;
        @(posedge clk); #1 frame = $urandom;
        @(posedge clk); #1 cs = 1'b0;
        @(posedge clk);
        @(posedge clk);
        model_frame(f[i]);
      end
      repeat (60) @(posedge clk);
      #1;
      n_checks++; if (qa_bcd.size() != 2) begin n_fail++; $display("FAIL overlap%0d_count got %0d want 2", run, qa_bcd.size()); end
      else begin
        n_checks++; if (qa_bcd[0] != 32'h0050 || qa_sign[0] != 0) begin n_fail++; $display("FAIL overlap%0d_first got %h/%0d want 0050/0", run, qa_bcd[0], qa_sign[0]); end
        n_checks++; if (qa_bcd[1] != exp_bcd(m_avg[0]) || qa_sign[1] != int'(m_avg[0] < 0)) begin n_fail++; $display("FAIL overlap%0d_second got %h/%0d want %h", run, qa_bcd[1], qa_sign[1], exp_bcd(m_avg[0])); end
      end
      n_checks++; if (tc_a !== 14'(m_avg[0])) begin n_fail++; $display("FAIL overlap%0d_tc got %h want %h", run, tc_a, 14'(m_avg[0])); end
    end
  endtask

  task automatic test_reset_mid();
    int e0;
    do_reset();
    frame = rev(mk(14'd1000, 1'b0, 12'h055, 3'b000));
    @(posedge clk); #1 cs = 1'b1;
    @(posedge clk); #1 frame = $urandom;
    repeat (7) @(posedge clk);
    #1 rst = 1'b1; cs = 1'b0;
    @(posedge clk); #1;
    n_checks++; if ({tc_a, int_a, flt_a, fl_a, bcd_a, sg_a, vl_a} !== '0) begin n_fail++; $display("FAIL midreset_outputs got %h want 0", {tc_a, int_a, bcd_a}); end
    rst = 1'b0;
    model_reset();
    repeat (30) @(posedge clk);
    #1;
    n_checks++; if (qa_bcd.size() != 0 || bcd_a !== 16'h0) begin n_fail++; $display("FAIL midreset_novalid got %0d/%h want 0/0000", qa_bcd.size(), bcd_a); end
    // Chip-select already high at reset release must not produce an event.
    rst = 1'b1; cs = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; frame = rev(mk(14'd800, 1'b0, 12'h077, 3'b000));
    repeat (30) @(posedge clk);
    #1;
    n_checks++; if (qa_bcd.size() != 0 || tc_a !== 14'h0 || int_a !== 12'h0) begin n_fail++; $display("FAIL cs_high_release got %0d/%h want 0/0", qa_bcd.size(), tc_a); end
    cs = 1'b0;
    @(posedge clk); #1;
    send_frame(mk(14'd800, 1'b0, 12'h077, 3'b000), e0);
    n_checks++; if (qa_bcd.size() != 1 || tc_a !== 14'd800) begin n_fail++; $display("FAIL after_release got %0d/%0d want 1/800", qa_bcd.size(), tc_a); end
  endtask

  task automatic test_random();
    int e0;
    logic [31:0] m;
    logic [13:0] tc;
    do_reset();
    for (int i = 0; i < 36; i++) begin
      case ($urandom_range(0, 5))
        0: tc = 14'h1FFF;
        1: tc = 14'h2000;
        default: tc = 14'($urandom);
      endcase
      m = mk(tc, ($urandom_range(0, 3) == 0), 12'($urandom), 3'($urandom)) | ($urandom & 32'h0002_0008);
      send_frame(m, e0);
      n_checks++; if (flt_a !== 1'(m_fault) || flt_b !== 1'(m_fault)) begin n_fail++; $display("FAIL rnd%0d_fault got %b/%b want %0d", i, flt_a, flt_b, m_fault); end
      n_checks++; if (fl_a !== 3'(m_flags) || fl_b !== 3'(m_flags)) begin n_fail++; $display("FAIL rnd%0d_flags got %b want %0d", i, fl_a, m_flags); end
      n_checks++; if (int_a !== 12'(m_int) || int_b !== 12'(m_int)) begin n_fail++; $display("FAIL rnd%0d_int got %h want %h", i, int_a, 12'(m_int)); end
      n_checks++; if (tc_a !== 14'(m_avg[0]) || tc_b !== 14'(m_avg[1])) begin n_fail++; $display("FAIL rnd%0d_tc got %h/%h want %h/%h", i, tc_a, tc_b, 14'(m_avg[0]), 14'(m_avg[1])); end
      n_checks++; if (qa_bcd.size() != m_vld[0] || qb_bcd.size() != m_vld[1]) begin n_fail++; $display("FAIL rnd%0d_valid got %0d/%0d want %0d/%0d", i, qa_bcd.size(), qb_bcd.size(), m_vld[0], m_vld[1]); end
      else begin
        if (m_vld[0] == 1) begin
          n_checks++; if (qa_bcd[0] != exp_bcd(m_avg[0]) || qa_sign[0] != int'(m_avg[0] < 0)) begin n_fail++; $display("FAIL rnd%0d_bcd_a got %h/%0d want %h", i, qa_bcd[0], qa_sign[0], exp_bcd(m_avg[0])); end
        end
        if (m_vld[1] == 1) begin
          n_checks++; if (qb_bcd[0] != exp_bcd(m_avg[1]) || qb_sign[0] != int'(m_avg[1] < 0)) begin n_fail++; $display("FAIL rnd%0d_bcd_b got %h/%0d want %h", i, qb_bcd[0], qb_sign[0], exp_bcd(m_avg[1])); end
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_good();
    test_extremes();
    test_averaging();
    test_fault_debounce();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
